// File: rtl/demux1_4_buf_if.sv
// Handshake bundle between one serial producer and the four lane consumers of demux1_4_buf.
// The slave modport is the demultiplexer side; the master modport is the producer/consumer side.
interface demux1_4_buf_if #(
  parameter int DW = 2
);
  logic [DW-1:0] din;
  logic          din_valid;
  logic [1:0]    din_sel;
  logic          auto_en;
  logic          din_ready;
  logic [DW-1:0] dout0;
  logic [DW-1:0] dout1;
  logic [DW-1:0] dout2;
  logic [DW-1:0] dout3;
  logic [3:0]    dout_valid;
  logic [3:0]    dout_ready;
  logic [1:0]    rr_ptr;

  modport master (
    output din, din_valid, din_sel, auto_en, dout_ready,
    input  din_ready, dout0, dout1, dout2, dout3, dout_valid, rr_ptr
  );

  modport slave (
    input  din, din_valid, din_sel, auto_en, dout_ready,
    output din_ready, dout0, dout1, dout2, dout3, dout_valid, rr_ptr
  );
endinterface

// File: rtl/demux1_4_buf.sv
// 1:4 registered demultiplexer: each lane owns a one-word buffer with its own valid/ready handshake.
// The target lane comes from din_sel (reversed mapping) or from a round-robin pointer.
module demux1_4_buf #(
  parameter int DW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  demux1_4_buf_if.slave   bus
);

  logic [3:0][DW-1:0] data_q, data_d;
  logic [3:0]         valid_q, valid_d;
  logic [1:0]         rr_q, rr_d;
  logic [1:0]         tgt;
  logic               accept;

  // Select code 00 addresses lane 3, so the explicit mapping is 3 - din_sel.
  assign tgt           = bus.auto_en ? rr_q : (2'd3 - bus.din_sel);
  assign bus.din_ready = rst_n & (~valid_q[tgt] | bus.dout_ready[tgt]);
  assign accept        = bus.din_valid & bus.din_ready;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    rr_d    = rr_q;
    for (int k = 0; k < 4; k++) begin
      // A load wins over a drain so a full lane can pass words through at full rate.
      if (accept && (tgt == 2'(k))) begin
        data_d[k]  = bus.din;
        valid_d[k] = 1'b1;
      end else if (valid_q[k] && bus.dout_ready[k]) begin
        valid_d[k] = 1'b0;
      end
    end
    if (accept && bus.auto_en) begin
      rr_d = rr_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 4'b0000;
      rr_q    <= 2'd0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.dout0      = data_q[0];
  assign bus.dout1      = data_q[1];
  assign bus.dout2      = data_q[2];
  assign bus.dout3      = data_q[3];
  assign bus.dout_valid = valid_q;
  assign bus.rr_ptr     = rr_q;

endmodule

// File: tb/tb_demux1_4_buf.sv
// Self-checking bench for demux1_4_buf: directed vector table, corner-case sequences and
// randomized traffic against a lane-buffer model of the routing rules.
module tb_demux1_4_buf;

  logic clk;
  logic rst_n;
  int   vecCount;
  int   missCount;

  demux1_4_buf_if #(.DW(2)) bus ();

  demux1_4_buf #(.DW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: one buffer per lane plus the round-robin index.
  logic [1:0] mData [4];
  bit         mValid[4];
  int         mPtr;

  typedef struct {
    logic [1:0] din;
    logic [1:0] sel;
    logic       autoEn;
    logic [3:0] rdy;
    logic       expReady;
    logic [3:0] expValid;
    int         expLane;
    logic [1:0] expData;
    logic [1:0] expPtr;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input int act, input int exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int laneData(input int idx);
    case (idx)
      0:       return int'(bus.dout0);
      1:       return int'(bus.dout1);
      2:       return int'(bus.dout2);
      default: return int'(bus.dout3);
    endcase
  endfunction

  function automatic int modelValidBits();
    int v = 0;
    for (int k = 0; k < 4; k++) if (mValid[k]) v += (1 << k);
    return v;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 4; k++) begin
      mData[k]  = 2'd0;
      mValid[k] = 1'b0;
    end
    mPtr = 0;
  endtask

  task automatic compareModel(input string tag);
    checkOutput({tag, "_valid"}, int'(bus.dout_valid), modelValidBits());
    checkOutput({tag, "_ptr"}, int'(bus.rr_ptr), mPtr);
    for (int k = 0; k < 4; k++) begin
      if (mValid[k]) checkOutput($sformatf("%s_dout%0d", tag, k), laneData(k), int'(mData[k]));
    end
  endtask

  // One clock of traffic: drive on the falling edge, check ready before the
  // rising edge, advance the model on the edge and compare the registered outputs.
  task automatic applyStimulus(input logic [1:0] din, input logic dv, input logic [1:0] sel,
                               input logic autoEn, input logic [3:0] rdy, input string tag,
                               output logic gotReady);
    int  tgt;
    bit  expReady;
    bit  acc;
    @(negedge clk);
    bus.din        = din;
    bus.din_valid  = dv;
    bus.din_sel    = sel;
    bus.auto_en    = autoEn;
    bus.dout_ready = rdy;
    #1;
    tgt      = autoEn ? mPtr : (3 - int'(sel));
    expReady = !mValid[tgt] || rdy[tgt];
    gotReady = bus.din_ready;
    checkOutput({tag, "_ready"}, int'(gotReady), int'(expReady));
    acc = dv && expReady;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (acc && tgt == k) begin
        mData[k]  = din;
        mValid[k] = 1'b1;
      end else if (mValid[k] && rdy[k]) begin
        mValid[k] = 1'b0;
      end
    end
    if (acc && autoEn) mPtr = (mPtr + 1) % 4;
    #1;
    compareModel(tag);
  endtask

  initial begin
    logic       rdyOut;
    logic [1:0] savedPtr;
    logic [3:0] savedValid;

    vecCount       = 0;
    missCount      = 0;
    rst_n          = 1'b0;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.din_sel    = 2'b00;
    bus.auto_en    = 1'b0;
    bus.dout_ready = 4'b0000;
    modelReset();

    // Explicit routing, then round-robin with wrap; all consumers ready.
    vecs[0] = '{2'd1, 2'b00, 1'b0, 4'hF, 1'b1, 4'b1000, 3, 2'd1, 2'd0};
    vecs[1] = '{2'd2, 2'b01, 1'b0, 4'hF, 1'b1, 4'b0100, 2, 2'd2, 2'd0};
    vecs[2] = '{2'd3, 2'b10, 1'b0, 4'hF, 1'b1, 4'b0010, 1, 2'd3, 2'd0};
    vecs[3] = '{2'd0, 2'b11, 1'b0, 4'hF, 1'b1, 4'b0001, 0, 2'd0, 2'd0};
    vecs[4] = '{2'd0, 2'b00, 1'b1, 4'hF, 1'b1, 4'b0001, 0, 2'd0, 2'd1};
    vecs[5] = '{2'd1, 2'b00, 1'b1, 4'hF, 1'b1, 4'b0010, 1, 2'd1, 2'd2};
    vecs[6] = '{2'd2, 2'b00, 1'b1, 4'hF, 1'b1, 4'b0100, 2, 2'd2, 2'd3};
    vecs[7] = '{2'd3, 2'b00, 1'b1, 4'hF, 1'b1, 4'b1000, 3, 2'd3, 2'd0};
    vecs[8] = '{2'd1, 2'b00, 1'b1, 4'hF, 1'b1, 4'b0001, 0, 2'd1, 2'd1};

    #3;
    checkOutput("rst_ready", int'(bus.din_ready), 0);
    checkOutput("rst_valid", int'(bus.dout_valid), 0);
    checkOutput("rst_ptr", int'(bus.rr_ptr), 0);
    checkOutput("rst_dout0", int'(bus.dout0), 0);
    checkOutput("rst_dout3", int'(bus.dout3), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_ready", int'(bus.din_ready), 1);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].din, 1'b1, vecs[i].sel, vecs[i].autoEn, vecs[i].rdy,
                    $sformatf("tbl%0d", i), rdyOut);
      checkOutput($sformatf("tbl%0d_exp_ready", i), int'(rdyOut), int'(vecs[i].expReady));
      checkOutput($sformatf("tbl%0d_exp_valid", i), int'(bus.dout_valid), int'(vecs[i].expValid));
      checkOutput($sformatf("tbl%0d_exp_data", i), laneData(vecs[i].expLane), int'(vecs[i].expData));
      checkOutput($sformatf("tbl%0d_exp_ptr", i), int'(bus.rr_ptr), int'(vecs[i].expPtr));
    end
    applyStimulus(2'd0, 1'b0, 2'b00, 1'b0, 4'hF, "drain", rdyOut);

    // Backpressure on lane 2 must not block lane 0 nor move the pointer.
    applyStimulus(2'd2, 1'b1, 2'b01, 1'b0, 4'b1011, "bp_load", rdyOut);
    applyStimulus(2'd3, 1'b1, 2'b01, 1'b0, 4'b1011, "bp_stall", rdyOut);
    checkOutput("bp_stall_ready_const", int'(rdyOut), 0);
    checkOutput("bp_hold_dout2", int'(bus.dout2), 2);
    checkOutput("bp_ptr_const", int'(bus.rr_ptr), 1);
    applyStimulus(2'd1, 1'b1, 2'b11, 1'b0, 4'b1011, "bp_lane0", rdyOut);
    checkOutput("bp_lane0_ready_const", int'(rdyOut), 1);
    checkOutput("bp_lane0_dout0", int'(bus.dout0), 1);
    checkOutput("bp_lane2_still", int'(bus.dout_valid[2]), 1);

    // Load and drain on lane 1 in the same cycle.
    applyStimulus(2'd1, 1'b1, 2'b10, 1'b0, 4'b0000, "ld_fill", rdyOut);
    applyStimulus(2'd2, 1'b1, 2'b10, 1'b0, 4'b0010, "ld_pass", rdyOut);
    checkOutput("ld_pass_ready_const", int'(rdyOut), 1);
    checkOutput("ld_pass_valid1", int'(bus.dout_valid[1]), 1);
    checkOutput("ld_pass_dout1", int'(bus.dout1), 2);

    // Idle cycles with a toggling select must change nothing.
    savedPtr   = bus.rr_ptr;
    savedValid = bus.dout_valid;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), 1'b0, 2'(i), 1'b1, 4'b0000, "gap", rdyOut);
      checkOutput("gap_ptr_const", int'(bus.rr_ptr), int'(savedPtr));
      checkOutput("gap_valid_const", int'(bus.dout_valid), int'(savedValid));
    end

    // Fill every lane, then assert reset asynchronously in mid-cycle.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'd3, 1'b1, 2'(i), 1'b0, 4'b0000, "fill", rdyOut);
    end
    checkOutput("fill_all_valid", int'(bus.dout_valid), 15);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("mrst_valid", int'(bus.dout_valid), 0);
    checkOutput("mrst_ready", int'(bus.din_ready), 0);
    checkOutput("mrst_ptr", int'(bus.rr_ptr), 0);
    checkOutput("mrst_dout1", int'(bus.dout1), 0);
    checkOutput("mrst_dout2", int'(bus.dout2), 0);
    @(negedge clk);
    rst_n          = 1'b1;
    bus.auto_en    = 1'b0;
    bus.din_sel    = 2'b00;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 4'b0000;
    #1;
    checkOutput("mrst_rel_ready", int'(bus.din_ready), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "rnd", rdyOut);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
